clsf_feature_packer: RTL and testbench

//  Upstream stage of clsf_tree: pops fixed-width words from the rx FIFO and assembles one feature vector per frame.

---
 rtl/clsf_feature_packer_pkg.sv | 28 ++
 rtl/clsf_feature_packer_sat_counter.sv | 24 ++
 rtl/clsf_feature_packer.sv | 114 +++++++++++
 tb/tb_clsf_feature_packer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/clsf_feature_packer_pkg.sv
// Shared widths and capture decode types for the classifier feature packer.
// Imported by the packer top and its saturating counter.
package clsf_feature_packer_pkg;

  localparam int TREE_INPUT_WIDTH = 576;
  localparam int WORD_WIDTH       = 32;
  localparam int ERR_WIDTH        = 16;

  function automatic int words_for(
    input int tree_w,
    input int word_w
  );
    return (tree_w + word_w - 1) / word_w;
  endfunction

  localparam int NUM_WORDS = words_for(TREE_INPUT_WIDTH, WORD_WIDTH);
  localparam int SOF_BIT   = WORD_WIDTH;

  typedef enum logic [2:0] {
    CAP_IDLE,
    CAP_FIRST,
    CAP_ORPHAN,
    CAP_RESYNC,
    CAP_NEXT,
    CAP_LAST
  } cap_e;

endpackage

// File: rtl/clsf_feature_packer_sat_counter.sv
// Saturating event counter with synchronous active-high clear.
// Holds at all-ones once reached; never wraps.
module clsf_feature_packer_sat_counter #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/clsf_feature_packer.sv
// Pops sof-tagged words from the rx FIFO and assembles one tree feature
// vector per frame, strobing data_valid for one cycle per vector.
module clsf_feature_packer
  import clsf_feature_packer_pkg::*;
#(
  parameter int TreeInputWidth = TREE_INPUT_WIDTH,
  parameter int WordWidth      = WORD_WIDTH
) (
  input  logic                      rx_fifo_clock,
  input  logic                      rx_fifo_reset,
  input  logic [WordWidth:0]        fifo_rdata,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  output logic [TreeInputWidth-1:0] data_out,
  output logic                      data_valid,
  output logic [ERR_WIDTH-1:0]      err_count
);

  localparam int NumWords = words_for(TreeInputWidth, WordWidth);
  localparam int IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int StageW   = (NumWords - 1) * WordWidth;
  localparam int LastW    = TreeInputWidth - StageW;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);
  localparam logic [IdxW-1:0] OneIdx  = IdxW'(1);

  logic                 rd_pending;
  logic [IdxW-1:0]      idx;
  logic [IdxW-1:0]      idx_nxt;
  logic [StageW-1:0]    staging;
  logic [WordWidth-1:0] payload;
  logic                 sof;
  logic                 first;
  logic                 last;
  logic                 err_inc;
  cap_e                 cap;

  assign payload = fifo_rdata[WordWidth-1:0];
  assign sof     = fifo_rdata[WordWidth];
  assign first   = (idx == '0);
  assign last    = (idx == LastIdx);

  // Reset gates the pop so nothing leaves the FIFO while it is held.
  assign fifo_rd_en = !fifo_empty && !rx_fifo_reset;

  always_comb begin
    cap = CAP_IDLE;
    unique case (1'b1)
      !rd_pending:                        cap = CAP_IDLE;
      rd_pending && first && sof:         cap = CAP_FIRST;
      rd_pending && first && !sof:        cap = CAP_ORPHAN;
      rd_pending && !first && sof:        cap = CAP_RESYNC;
      rd_pending && !first && !sof && last:  cap = CAP_LAST;
      rd_pending && !first && !sof && !last: cap = CAP_NEXT;
      default:                            cap = CAP_IDLE;
    endcase
  end

  always_comb begin
    idx_nxt = idx;
    err_inc = 1'b0;
    unique case (cap)
      CAP_FIRST:  idx_nxt = OneIdx;
      CAP_RESYNC: begin
        idx_nxt = OneIdx;
        err_inc = 1'b1;
      end
      CAP_ORPHAN: err_inc = 1'b1;
      CAP_NEXT:   idx_nxt = idx + OneIdx;
      CAP_LAST:   idx_nxt = '0;
      default:    idx_nxt = idx;
    endcase
  end

  always_ff @(posedge rx_fifo_clock) begin
    if (rx_fifo_reset) begin
      rd_pending <= 1'b0;
      idx        <= '0;
      data_valid <= 1'b0;
    end else begin
      rd_pending <= fifo_rd_en;
      idx        <= idx_nxt;
      data_valid <= (cap == CAP_LAST);
    end
  end

  // Stale slots after a resync are simply overwritten before the next strobe.
  always_ff @(posedge rx_fifo_clock) begin
    if (rx_fifo_reset) begin
      staging  <= '0;
      data_out <= '0;
    end else begin
      if (cap == CAP_FIRST || cap == CAP_RESYNC) begin
        staging[WordWidth-1:0] <= payload;
      end
      if (cap == CAP_NEXT) begin
        staging[int'(idx)*WordWidth +: WordWidth] <= payload;
      end
      if (cap == CAP_LAST) begin
        data_out <= {payload[LastW-1:0], staging};
      end
    end
  end

  clsf_feature_packer_sat_counter #(
    .Width(ERR_WIDTH)
  ) u_err_cnt (
    .clk   (rx_fifo_clock),
    .rst   (rx_fifo_reset),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_clsf_feature_packer.sv
// Directed bench for clsf_feature_packer: table of framing scenarios
// plus hand sequences for back-to-back vectors and mid-vector reset.
module tb_clsf_feature_packer;

  localparam int TW = 576;
  localparam int WW = 32;
  localparam int NW = 18;
  localparam int MEMD = 1024;

  logic          clk = 1'b0;
  logic          rx_fifo_reset = 1'b1;
  logic [WW:0]   fifo_rdata = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [TW-1:0] data_out;
  logic          data_valid;
  logic [15:0]   err_count;

  clsf_feature_packer dut (
    .rx_fifo_clock (clk),
    .rx_fifo_reset (rx_fifo_reset),
    .fifo_rdata    (fifo_rdata),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  // FIFO model: one-cycle read latency
  logic [WW:0] mem [MEMD];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        gate = 1'b0;
  logic        flush = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr) || gate;

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr % MEMD];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Monitor
  int          cyc = 0;
  int          pulses = 0;
  int          last_pulse = 0;
  int          prev_pulse = 0;
  int          last_rd = 0;
  int          empty_viol = 0;
  int          stab_viol = 0;
  logic        have = 1'b0;
  logic [TW-1:0] held = '0;
  logic [TW-1:0] first_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_fifo_reset) begin
      pulses     <= 0;
      empty_viol <= 0;
      stab_viol  <= 0;
      have       <= 1'b0;
    end else begin
      if (fifo_rd_en && fifo_empty) empty_viol <= empty_viol + 1;
      if (fifo_rd_en) last_rd <= cyc;
      if (data_valid) begin
        pulses     <= pulses + 1;
        prev_pulse <= last_pulse;
        last_pulse <= cyc;
        held       <= data_out;
        have       <= 1'b1;
        if (pulses == 0) first_data <= data_out;
      end else if (have && data_out != held) begin
        stab_viol <= stab_viol + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [TW-1:0] act,
                     input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sof, input int pl);
    mem[wr_ptr % MEMD] = {sof, 32'(pl)};
    wr_ptr++;
  endtask

  task automatic push_vec(input int base);
    for (int i = 0; i < NW; i++) push(i == 0, base + i);
  endtask

  task automatic do_reset(input int n);
    rx_fifo_reset = 1'b1;
    flush = 1'b1;
    gate = 1'b0;
    repeat (n) step();
    rx_fifo_reset = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain(input string name, input bit toggle);
    int n = 0;
    while (rd_ptr != wr_ptr && n < 400) begin
      if (toggle) gate = ~gate;
      step();
      n++;
    end
    gate = 1'b0;
    repeat (4) step();
    chk({name, "_drain_timeout"}, TW'(n < 400), TW'(1));
  endtask

  function automatic logic [TW-1:0] vec_of(input int base);
    logic [TW-1:0] v = '0;
    for (int i = 0; i < NW; i++) v[i*WW +: WW] = 32'(base + i);
    return v;
  endfunction

  typedef struct {
    int orphans;
    int abort_at;
    int base;
    int base2;
    bit toggle;
    int exp_err;
    int exp_base;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int n_rd;
    int guard;
    string nm;

    // basic, toggled empty, resync at word 5, three orphans
    tbl[0] = '{0, 0, 0,   0,   1'b0, 0, 0};
    tbl[1] = '{0, 0, 0,   0,   1'b1, 0, 0};
    tbl[2] = '{0, 5, 0,   200, 1'b0, 1, 200};
    tbl[3] = '{3, 0, 0,   0,   1'b0, 3, 0};

    do_reset(3);
    rx_fifo_reset = 1'b1;
    push(1'b1, 55);
    #1;
    chk("rst_rd_en", TW'(fifo_rd_en), TW'(0));
    step();
    chk("rst_data_out", data_out, '0);
    chk("rst_data_valid", TW'(data_valid), TW'(0));
    chk("rst_err_count", TW'(err_count), TW'(0));
    do_reset(2);

    for (int t = 0; t < 4; t++) begin
      nm = $sformatf("v%0d", t);
      do_reset(2);
      for (int k = 0; k < tbl[t].orphans; k++) push(1'b0, 900 + k);
      if (tbl[t].abort_at > 0) begin
        for (int i = 0; i < tbl[t].abort_at; i++)
          push(i == 0, tbl[t].base + i);
        push_vec(tbl[t].base2);
      end else begin
        push_vec(tbl[t].base);
      end
      drain(nm, tbl[t].toggle);
      chk({nm, "_pulses"}, TW'(pulses), TW'(1));
      chk({nm, "_err"}, TW'(err_count), TW'(tbl[t].exp_err));
      chk({nm, "_data"}, data_out, vec_of(tbl[t].exp_base));
      chk({nm, "_latency"}, TW'(last_pulse - last_rd), TW'(2));
      chk({nm, "_rd_while_empty"}, TW'(empty_viol), TW'(0));
    end

    // back-to-back vectors
    do_reset(2);
    push_vec(0);
    push_vec(100);
    drain("b2b", 1'b0);
    chk("b2b_pulses", TW'(pulses), TW'(2));
    chk("b2b_spacing", TW'(last_pulse - prev_pulse), TW'(NW));
    chk("b2b_first", first_data, vec_of(0));
    chk("b2b_second", data_out, vec_of(100));
    chk("b2b_stable", TW'(stab_viol), TW'(0));
    chk("b2b_err", TW'(err_count), TW'(0));

    // reset one cycle after the 7th pop; that word is in flight
    do_reset(2);
    push_vec(0);
    n_rd = 0;
    guard = 0;
    while (guard < 100) begin
      if (fifo_rd_en) n_rd++;
      if (n_rd == 7) break;
      step();
      guard++;
    end
    chk("mid_rst_reach7", TW'(n_rd), TW'(7));
    step();
    rx_fifo_reset = 1'b1;
    flush = 1'b1;
    #1;
    chk("mid_rst_rd_en0", TW'(fifo_rd_en), TW'(0));
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("mid_rst_out_c%0d", c),
          TW'({data_valid, fifo_rd_en, err_count}) | data_out, '0);
    end
    rx_fifo_reset = 1'b0;
    flush = 1'b0;
    push_vec(300);
    drain("post_rst", 1'b0);
    chk("post_rst_pulses", TW'(pulses), TW'(1));
    chk("post_rst_data", data_out, vec_of(300));
    chk("post_rst_err", TW'(err_count), TW'(0));
    chk("post_rst_latency", TW'(last_pulse - last_rd), TW'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
